// File: rtl/clk_div_sched.sv
// clk_div_sched: even-ratio clock divider whose ratio can be changed at run
// time by two requesters (0 = host command path, 1 = codec/audio path).
// Requests are arbitrated round-robin and validated; an accepted divisor is
// held pending and swapped in only at the end of a high phase, so clk_out
// never produces a runt pulse.
//
// Ports:
//   clk_in          source clock, all logic on its rising edge
//   reset           synchronous, active-high reset
//   req0/div0       requester 0 level request and requested divisor
//   ack0/nak0       requester 0 applied / rejected pulses (1 cycle)
//   req1/div1       requester 1 level request and requested divisor
//   ack1/nak1       requester 1 applied / rejected pulses (1 cycle)
//   busy            a validated change is waiting for its boundary
//   clk_out         divided clock, 50% duty, registered
//   cur_div         divisor currently in effect
//   tick            1-cycle pulse in the cycle clk_out becomes 1
module clk_div_sched #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             req0,
  input  logic [DIV_W-1:0] div0,
  output logic             ack0,
  output logic             nak0,
  input  logic             req1,
  input  logic [DIV_W-1:0] div1,
  output logic             ack1,
  output logic             nak1,
  output logic             busy,
  output logic             clk_out,
  output logic [DIV_W-1:0] cur_div,
  output logic             tick
);

  localparam logic [0:0]       ST_IDLE = 1'b0;
  localparam logic [0:0]       ST_PEND = 1'b1;
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  logic [0:0]       state_q, state_d;
  logic [DIV_W-2:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_div_q;
  logic             pend_owner_q, pend_owner_d;
  // Requester granted most recently; reset to 1 so requester 0 wins first tie.
  logic             last_q, last_d;
  logic             ack0_q, ack0_d, nak0_q, nak0_d;
  logic             ack1_q, ack1_d, nak1_q, nak1_d;

  logic [DIV_W-2:0] half;
  logic [DIV_W-2:0] half_m1;
  logic             at_end;
  logic             elig0, elig1;
  logic             gnt0, gnt1;
  logic [DIV_W-1:0] gnt_div;
  logic             gnt_ok;
  logic             load_pend;

  assign half    = cur_div_q[DIV_W-1:1];
  assign half_m1 = half - (DIV_W-1)'(1);
  assign at_end  = (cnt_q == half_m1);

  always_comb begin
    // A requester whose ack/nak is showing this cycle is still holding req
    // from the finished transaction, so it is not eligible again yet.
    elig0 = req0 & ~ack0_q & ~nak0_q;
    elig1 = req1 & ~ack1_q & ~nak1_q;
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (elig0 && elig1) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = elig0;
        gnt1 = elig1;
      end
    end
    gnt_div = gnt1 ? div1 : div0;
    // Even and non-zero is the same as even and >= 2.
    gnt_ok  = ~gnt_div[0] && (gnt_div != '0);
  end

  always_comb begin
    cnt_d        = cnt_q + (DIV_W-1)'(1);
    clk_out_d    = clk_out_q;
    tick_d       = 1'b0;
    cur_div_d    = cur_div_q;
    state_d      = state_q;
    pend_owner_d = pend_owner_q;
    last_d       = last_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    nak0_d       = 1'b0;
    nak1_d       = 1'b0;
    load_pend    = 1'b0;

    if (at_end) begin
      cnt_d = '0;
      if (state_q == ST_PEND && clk_out_q) begin
        // End of a high phase: swap ratio; the low phase that starts now
        // already uses the new half period.
        cur_div_d = pend_div_q;
        clk_out_d = 1'b0;
        state_d   = ST_IDLE;
        ack0_d    = ~pend_owner_q;
        ack1_d    = pend_owner_q;
      end else begin
        clk_out_d = ~clk_out_q;
        tick_d    = ~clk_out_q;
      end
    end

    // Grants only happen in IDLE, so they never collide with an apply.
    if (gnt0 || gnt1) begin
      last_d = gnt1;
      if (gnt_ok) begin
        state_d      = ST_PEND;
        pend_owner_d = gnt1;
        load_pend    = 1'b1;
      end else begin
        nak0_d = gnt0;
        nak1_d = gnt1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
      cur_div_q    <= DEF_DIV;
      pend_owner_q <= 1'b0;
      last_q       <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      nak0_q       <= 1'b0;
      nak1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
      cur_div_q    <= cur_div_d;
      pend_owner_q <= pend_owner_d;
      last_q       <= last_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      nak0_q       <= nak0_d;
      nak1_q       <= nak1_d;
    end
  end

  // Pending divisor is only meaningful while state_q is PENDING.
  always_ff @(posedge clk_in) begin
    if (load_pend) begin
      pend_div_q <= gnt_div;
    end
  end

  assign ack0    = ack0_q;
  assign nak0    = nak0_q;
  assign ack1    = ack1_q;
  assign nak1    = nak1_q;
  assign busy    = (state_q == ST_PEND);
  assign clk_out = clk_out_q;
  assign cur_div = cur_div_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_sched.sv
module tb_clk_div_sched;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic        req0   = 1'b0;
  logic [15:0] div0   = '0;
  logic        req1   = 1'b0;
  logic [15:0] div1   = '0;
  logic        ack0, nak0, ack1, nak1, busy, clk_out, tick;
  logic [15:0] cur_div;

  int checks   = 0;
  int failures = 0;

  clk_div_sched #(.DIV_W(16), .DEFAULT_DIV(10)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .req0   (req0),
    .div0   (div0),
    .ack0   (ack0),
    .nak0   (nak0),
    .req1   (req1),
    .div1   (div1),
    .ack1   (ack1),
    .nak1   (nak1),
    .busy   (busy),
    .clk_out(clk_out),
    .cur_div(cur_div),
    .tick   (tick)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: event-scheduled. m_end is the absolute edge index at
  // which the current phase finishes; a pending divisor is taken only when a
  // high phase finishes.
  int m_t = 0;
  int m_end = 0;
  int m_div = 10;
  int m_pdiv = 0;
  bit m_clk = 0;
  bit m_pend = 0;
  bit m_powner = 0;
  bit m_last = 1;
  bit e_tick = 0, e_ack0 = 0, e_nak0 = 0, e_ack1 = 0, e_nak1 = 0;
  bit drop0 = 0, drop1 = 0;

  task automatic m_step();
    bit el0, el1, g0, g1;
    int d;
    m_t++;
    if (reset) begin
      m_div = 10; m_clk = 0; m_end = m_t + 5; m_pend = 0; m_last = 1;
      e_tick = 0; e_ack0 = 0; e_nak0 = 0; e_ack1 = 0; e_nak1 = 0;
      return;
    end
    el0 = req0 && !e_ack0 && !e_nak0;
    el1 = req1 && !e_ack1 && !e_nak1;
    g0 = 0; g1 = 0;
    if (!m_pend) begin
      if (el0 && el1) begin
        if (m_last) g0 = 1; else g1 = 1;
      end else begin
        g0 = el0; g1 = el1;
      end
    end
    d = g1 ? int'(div1) : int'(div0);
    e_tick = 0; e_ack0 = 0; e_nak0 = 0; e_ack1 = 0; e_nak1 = 0;
    if (m_t == m_end) begin
      if (m_pend && m_clk) begin
        m_div = m_pdiv; m_clk = 0; m_pend = 0;
        if (m_powner) e_ack1 = 1; else e_ack0 = 1;
      end else begin
        m_clk = !m_clk;
        e_tick = m_clk;
      end
      m_end = m_t + m_div / 2;
    end
    if (g0 || g1) begin
      m_last = g1;
      if ((d % 2 == 0) && d >= 2) begin
        m_pend = 1; m_pdiv = d; m_powner = g1;
      end else if (g0) begin
        e_nak0 = 1;
      end else begin
        e_nak1 = 1;
      end
    end
  endtask

  // Advance one clock; requesters drop req the cycle after their ack/nak.
  task automatic cycle();
    m_step();
    @(posedge clk_in);
    #1;
    if (drop0) req0 = 0;
    if (drop1) req1 = 0;
    drop0 = e_ack0 || e_nak0;
    drop1 = e_ack1 || e_nak1;
  endtask

  function automatic logic [22:0] dut_vec();
    return {clk_out, tick, busy, ack0, nak0, ack1, nak1, cur_div};
  endfunction

  function automatic logic [22:0] mdl_vec();
    return {m_clk, e_tick, m_pend, e_ack0, e_nak0, e_ack1, e_nak1, 16'(m_div)};
  endfunction

  task automatic apply_reset();
    reset = 1; req0 = 0; req1 = 0; drop0 = 0; drop1 = 0;
    cycle();
    cycle();
    reset = 0;
  endtask

  task automatic test_reset();
    int tick_at[3];
    int nt = 0;
    apply_reset();
    checks++;
    if ({clk_out, tick, busy, ack0, nak0, ack1, nak1} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=0000000", {clk_out, tick, busy, ack0, nak0, ack1, nak1});
    end
    checks++;
    if (cur_div !== 16'd10) begin
      failures++;
      $display("FAIL reset_cur_div got=%0d exp=10", cur_div);
    end
    for (int i = 1; i <= 40; i++) begin
      cycle();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL reset_run cyc=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
      if (tick) begin
        if (nt < 3) tick_at[nt] = i;
        nt++;
      end
    end
    checks++;
    if (nt !== 4 || tick_at[0] !== 5 || tick_at[1] !== 15 || tick_at[2] !== 25) begin
      failures++;
      $display("FAIL reset_ticks got n=%0d t=%0d,%0d,%0d exp n=4 t=5,15,25", nt, tick_at[0], tick_at[1], tick_at[2]);
    end
  endtask

  task automatic test_change4();
    int n_ack = 0;
    int k = 0;
    apply_reset();
    while (!tick && k < 20) begin cycle(); k++; end
    checks++;
    if (!tick) begin
      failures++;
      $display("FAIL change4_wait_tick got=timeout exp=tick");
    end
    cycle();
    req0 = 1; div0 = 16'd4;
    cycle();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL change4_busy got=%b exp=1", busy);
    end
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL change4_run cyc=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
      if (ack0) n_ack++;
      cycle();
    end
    checks++;
    if (n_ack !== 1 || cur_div !== 16'd4) begin
      failures++;
      $display("FAIL change4_done got acks=%0d div=%0d exp acks=1 div=4", n_ack, cur_div);
    end
  endtask

  task automatic test_invalid();
    int n_ack = 0;
    apply_reset();
    req0 = 1; div0 = 16'd7;
    cycle();
    checks++;
    if (nak0 !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL invalid_nak0 got nak0=%b busy=%b exp nak0=1 busy=0", nak0, busy);
    end
    cycle();
    cycle();
    req1 = 1; div1 = 16'd1;
    cycle();
    checks++;
    if (nak1 !== 1'b1 || nak0 !== 1'b0) begin
      failures++;
      $display("FAIL invalid_nak1 got nak1=%b nak0=%b exp nak1=1 nak0=0", nak1, nak0);
    end
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL invalid_run cyc=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
      if (ack0 || ack1) n_ack++;
      cycle();
    end
    checks++;
    if (n_ack !== 0 || cur_div !== 16'd10) begin
      failures++;
      $display("FAIL invalid_done got acks=%0d div=%0d exp acks=0 div=10", n_ack, cur_div);
    end
  endtask

  task automatic test_simultaneous();
    int t0 = -1;
    int t1 = -1;
    apply_reset();
    req0 = 1; div0 = 16'd6;
    req1 = 1; div1 = 16'd8;
    for (int i = 0; i < 80; i++) begin
      cycle();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL simul_run cyc=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
      if (ack0 && t0 < 0) t0 = i;
      if (ack1 && t1 < 0) t1 = i;
    end
    checks++;
    if (t0 < 0 || t1 <= t0 || cur_div !== 16'd8) begin
      failures++;
      $display("FAIL simul_order got t0=%0d t1=%0d div=%0d exp 0<=t0<t1 div=8", t0, t1, cur_div);
    end
  endtask

  task automatic test_reset_pending();
    int n_ack = 0;
    apply_reset();
    req0 = 1; div0 = 16'd20;
    cycle();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rstpend_busy got=%b exp=1", busy);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (ack0) n_ack++;
    end
    reset = 1; req0 = 0;
    cycle();
    reset = 0;
    checks++;
    if (busy !== 1'b0 || ack0 !== 1'b0 || cur_div !== 16'd10) begin
      failures++;
      $display("FAIL rstpend_after got busy=%b ack0=%b div=%0d exp busy=0 ack0=0 div=10", busy, ack0, cur_div);
    end
    for (int i = 0; i < 30; i++) begin
      cycle();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL rstpend_run cyc=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
      if (ack0) n_ack++;
    end
    checks++;
    if (n_ack !== 0) begin
      failures++;
      $display("FAIL rstpend_noack got=%0d exp=0", n_ack);
    end
  endtask

  task automatic test_back_to_back();
    int n_ack = 0;
    int k;
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      req1 = 1; div1 = (r == 0) ? 16'd2 : 16'd12;
      k = 0;
      while (k < 40) begin
        cycle();
        k++;
        checks++;
        if (dut_vec() !== mdl_vec()) begin
          failures++;
          $display("FAIL b2b_run r=%0d cyc=%0d got=%h exp=%h", r, k, dut_vec(), mdl_vec());
        end
        if (ack1) break;
      end
      if (ack1) n_ack++;
      cycle();
      cycle();
    end
    for (int i = 0; i < 30; i++) begin
      cycle();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL b2b_tail cyc=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (n_ack !== 2 || cur_div !== 16'd12) begin
      failures++;
      $display("FAIL b2b_done got acks=%0d div=%0d exp acks=2 div=12", n_ack, cur_div);
    end
  endtask

  task automatic test_random();
    int both = 0;
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      if (!req0 && !drop0 && $urandom_range(0, 5) == 0) begin
        req0 = 1; div0 = 16'($urandom_range(0, 24));
      end
      if (!req1 && !drop1 && $urandom_range(0, 5) == 0) begin
        req1 = 1; div1 = 16'($urandom_range(0, 24));
      end
      cycle();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL random_run cyc=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
      if ((ack0 || nak0) && (ack1 || nak1)) both++;
    end
    checks++;
    if (both !== 0) begin
      failures++;
      $display("FAIL random_exclusive got=%0d exp=0", both);
    end
  endtask

  initial begin
    test_reset();
    test_change4();
    test_invalid();
    test_simultaneous();
    test_reset_pending();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
